// File: rtl/bit_scheduler.sv
// Serialises bytes MSB-first behind an alternating preamble into a bit FIFO, one write per symbol slot.
// First write two cycles after accept; a full FIFO freezes the slot so no bit is lost or repeated.
module bit_scheduler #(
  parameter int SYM_CLKS = 256,
  parameter int PRE_BITS = 8,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  input  logic             fifo_full,
  output logic             wr_en,
  output logic             wr_bit,
  output logic             busy,
  output logic [CNT_W-1:0] bytes_sent
);

  localparam int            SW       = (SYM_CLKS > 2) ? $clog2(SYM_CLKS) : 1;
  localparam logic [SW-1:0] SYM_LAST = SW'(SYM_CLKS - 1);
  localparam int            PW       = $clog2(PRE_BITS + 2);
  localparam logic [PW-1:0] PRE_LAST = PW'((PRE_BITS > 0) ? PRE_BITS - 1 : 0);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;

  state_t        state;
  logic [SW-1:0] sym_cnt;
  logic [2:0]    bit_idx;
  logic [PW-1:0] pre_cnt;
  logic [7:0]    shift;
  logic          slot;
  logic          wr_go;
  logic          last_bit;
  logic          accept;

  assign slot     = (state != IDLE) && (sym_cnt == '0);
  assign wr_go    = slot && !fifo_full;
  assign last_bit = (state == DATA) && (bit_idx == 3'd0);
  // A new byte may be taken only as the current byte's last bit is committed, so framing never gaps.
  assign s_ready  = RST && ((state == IDLE) || (wr_go && last_bit));
  assign accept   = s_valid && s_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      sym_cnt    <= '0;
      bit_idx    <= 3'd0;
      pre_cnt    <= '0;
      shift      <= 8'd0;
      wr_en      <= 1'b0;
      wr_bit     <= 1'b0;
      bytes_sent <= '0;
    end else begin
      wr_en <= 1'b0;
      // Holding the counter at zero keeps the stalled slot open until the FIFO drains.
      if ((state != IDLE) && !(slot && fifo_full))
        sym_cnt <= (sym_cnt == SYM_LAST) ? '0 : sym_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (accept) begin
            shift   <= s_data;
            sym_cnt <= '0;
            bit_idx <= 3'd7;
            pre_cnt <= '0;
            state   <= (PRE_BITS > 0) ? PREAMBLE : DATA;
          end
        end
        PREAMBLE: begin
          if (wr_go) begin
            wr_en   <= 1'b1;
            wr_bit  <= ~pre_cnt[0];
            pre_cnt <= pre_cnt + 1'b1;
            if (pre_cnt == PRE_LAST)
              state <= DATA;
          end
        end
        DATA: begin
          if (wr_go) begin
            wr_en   <= 1'b1;
            wr_bit  <= shift[bit_idx];
            bit_idx <= bit_idx - 1'b1;
            if (bit_idx == 3'd0) begin
              bytes_sent <= bytes_sent + 1'b1;
              if (accept) begin
                shift   <= s_data;
                bit_idx <= 3'd7;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
